// File: rtl/math_pkg.sv
// Shared definitions for the math library: divider FSM state encoding.
package math_pkg;

  typedef logic [1:0] div_state_t;

  localparam div_state_t DIV_IDLE = 2'd0;
  localparam div_state_t DIV_CALC = 2'd1;
  localparam div_state_t DIV_DONE = 2'd2;

endpackage

// File: rtl/math_subtractor_carry_lookahead.sv
// N-bit subtractor a - b - borrow_in built from generate/propagate terms of a + ~b.
// ow_carry_out is the borrow out: high when a < b + borrow_in.
module math_subtractor_carry_lookahead #(
  parameter int unsigned N = 9
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_borrow_in,
  output logic [N-1:0] o_diff,
  output logic         ow_carry_out
);

  logic [N-1:0] gen;
  logic [N-1:0] prop;
  logic [N:0]   carry;

  assign gen  = i_a & ~i_b;
  assign prop = i_a ^ ~i_b;

  always_comb begin
    carry    = '0;
    carry[0] = ~i_borrow_in;
    for (int i = 0; i < N; i++) begin
      carry[i+1] = gen[i] | (prop[i] & carry[i]);
    end
  end

  assign o_diff       = prop ^ carry[N-1:0];
  assign ow_carry_out = ~carry[N];

endmodule

// File: rtl/math_divider_restoring_seq.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// start/busy/done handshake; results held until the next completed divide.
module math_divider_restoring_seq
  import math_pkg::*;
#(
  parameter int unsigned N = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [N-1:0] i_dividend,
  input  logic [N-1:0] i_divisor,
  output logic         o_busy,
  output logic         o_done,
  output logic [N-1:0] o_quotient,
  output logic [N-1:0] o_remainder,
  output logic         o_div_by_zero
);

  localparam int unsigned CW = $clog2(N);

  div_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  q_q, q_d;
  logic [N:0]    r_q, r_d;
  logic [N-1:0]  d_q, d_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [N-1:0]  rem_q, rem_d;
  logic          dbz_q, dbz_d;

  logic [N:0]    r_shift;
  logic [N:0]    diff;
  logic          borrow;
  logic          accept;
  logic [N:0]    r_step;
  logic [N-1:0]  q_step;

  assign r_shift = {r_q[N-1:0], q_q[N-1]};

  math_subtractor_carry_lookahead #(
    .N (N + 1)
  ) u_sub (
    .i_a          (r_shift),
    .i_b          ({1'b0, d_q}),
    .i_borrow_in  (1'b0),
    .o_diff       (diff),
    .ow_carry_out (borrow)
  );

  // A set R[N] would mean the shifted value exceeds any divisor; it stays 0 in practice.
  assign accept = ~borrow | r_q[N];
  assign r_step = accept ? diff : r_shift;
  assign q_step = {q_q[N-2:0], accept};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      DIV_IDLE: begin
        if (i_start) begin
          if (i_divisor != '0) begin
            state_d = DIV_CALC;
            q_d     = i_dividend;
            d_d     = i_divisor;
            r_d     = '0;
            cnt_d   = CW'(N - 1);
          end else begin
            state_d = DIV_DONE;
            quo_d   = '1;
            rem_d   = i_dividend;
            dbz_d   = 1'b1;
          end
        end
      end
      DIV_CALC: begin
        q_d   = q_step;
        r_d   = r_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = DIV_DONE;
          quo_d   = q_step;
          rem_d   = r_step[N-1:0];
          dbz_d   = 1'b0;
        end
      end
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign o_busy        = (state_q != DIV_IDLE);
  assign o_done        = (state_q == DIV_DONE);
  assign o_quotient    = quo_q;
  assign o_remainder   = rem_q;
  assign o_div_by_zero = dbz_q;

endmodule

// File: tb/tb_math_divider_restoring_seq.sv
// Self-checking bench for math_divider_restoring_seq (N=8): directed cases plus
// random operands against an arithmetic reference model.
module tb_math_divider_restoring_seq;

  localparam int unsigned N = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         dbz;

  int n_checks = 0;
  int n_pass   = 0;
  logic done_prev = 1'b0;

  math_divider_restoring_seq #(
    .N (N)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_dividend    (dividend),
    .i_divisor     (divisor),
    .o_busy        (busy),
    .o_done        (done),
    .o_quotient    (quotient),
    .o_remainder   (remainder),
    .o_div_by_zero (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // o_done must be a one-cycle pulse and imply busy
  always @(negedge clk) begin
    if (rst_n && done) begin
      check("done_single_pulse", {31'b0, done_prev}, 32'd0);
      check("busy_with_done", {31'b0, busy}, 32'd1);
    end
    done_prev = rst_n ? done : 1'b0;
  end

  // Wait (sampling on negedges) for o_done; optionally hammer start with junk operands.
  task automatic wait_done(input bit noisy, output int lat);
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (lat == 1) check("busy_after_start", {31'b0, busy}, 32'd1);
      if (done) break;
      if (lat > N + 4) begin
        check("done_timeout", {31'b0, done}, 32'd1);
        break;
      end
      if (noisy) begin
        start    = 1'b1;
        dividend = N'($urandom);
        divisor  = N'($urandom);
      end
    end
    start = 1'b0;
  endtask

  task automatic do_div(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                        input bit noisy);
    int lat;
    logic [N-1:0] exp_q, exp_r;
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = N'($urandom);
    divisor  = N'($urandom);
    wait_done(noisy, lat);
    exp_q = (b == 0) ? {N{1'b1}} : N'(a / b);
    exp_r = (b == 0) ? a : N'(a % b);
    check({tag, "_latency"}, lat, (b == 0) ? 32'd1 : N + 1);
    check({tag, "_q"}, {24'b0, quotient}, {24'b0, exp_q});
    check({tag, "_r"}, {24'b0, remainder}, {24'b0, exp_r});
    check({tag, "_dbz"}, {31'b0, dbz}, {31'b0, (b == 0)});
  endtask

  initial begin
    int lat;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_q", {24'b0, quotient}, 32'd0);
    check("rst_r", {24'b0, remainder}, 32'd0);
    check("rst_dbz", {31'b0, dbz}, 32'd0);
    rst_n = 1'b1;

    // Reset in the middle of a divide
    @(negedge clk);
    start = 1'b1; dividend = 8'd200; divisor = 8'd3;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    check("midrst_q", {24'b0, quotient}, 32'd0);
    check("midrst_r", {24'b0, remainder}, 32'd0);
    repeat (3) @(negedge clk);
    check("midrst_no_done", {31'b0, done}, 32'd0);
    rst_n = 1'b1;
    do_div("after_rst", 8'd9, 8'd3, 1'b0);

    do_div("d100_7", 8'd100, 8'd7, 1'b0);
    @(negedge clk);
    check("hold_q", {24'b0, quotient}, 32'd14);
    check("hold_done_low", {31'b0, done}, 32'd0);
    do_div("d255_1", 8'd255, 8'd1, 1'b0);
    do_div("d5_9", 8'd5, 8'd9, 1'b0);
    do_div("d255_255", 8'd255, 8'd255, 1'b0);
    do_div("d42_0", 8'd42, 8'd0, 1'b0);
    do_div("d42_5", 8'd42, 8'd5, 1'b0);

    // Start hammered while busy; operands must not be resampled
    do_div("noisy100_7", 8'd100, 8'd7, 1'b1);
    // At the done negedge start is held high: edge k+N+1 only leaves DONE,
    // so the first IDLE cycle follows and acceptance happens one edge later.
    start = 1'b1; dividend = 8'd50; divisor = 8'd5;
    @(negedge clk);
    check("b2b_idle_gap", {31'b0, busy}, 32'd0);
    @(negedge clk);
    check("b2b_accepted", {31'b0, busy}, 32'd1);
    start = 1'b0;
    wait_done(1'b0, lat);
    check("b2b_q", {24'b0, quotient}, 32'd10);
    check("b2b_r", {24'b0, remainder}, 32'd0);

    for (int i = 0; i < 2000; i++) begin
      logic [N-1:0] a, b;
      a = N'($urandom);
      b = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
      do_div("rand", a, b, ($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
